// File: rtl/index_row_grouper_pkg.sv
// Shared sparse-matrix definitions: index width default, grouper state encoding
// and the log2 helper used to size FIFO pointers.
package index_row_grouper_pkg;

  localparam int INDEX_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN       = 2'd1,
    FLUSH_PEND = 2'd2
  } grp_state_t;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/index_row_grouper_fifo.sv
// Index FIFO: power-of-two ring buffer with a full-width occupancy count.
// The head word is shown combinationally and reads as zero while empty.
module index_fifo
  import index_row_grouper_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_ok   = rd_en && valid;
  // A write into a full buffer is only safe when the head leaves in the same cycle.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/index_row_grouper.sv
// Buffers (row, col) pairs from the pattern decoder and groups them into rows,
// flagging row starts and reporting each closed row with its nonzero count.
module index_row_grouper
  import index_row_grouper_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int DEPTH       = 16,
  parameter int SLACK       = 4
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   index_push,
  input  logic [INDEX_WIDTH-1:0] row,
  input  logic [INDEX_WIDTH-1:0] col,
  input  logic                   flush,
  output logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_row,
  output logic [INDEX_WIDTH-1:0] out_col,
  output logic                   out_row_start,
  output logic                   row_done,
  output logic [INDEX_WIDTH-1:0] done_row,
  output logic [INDEX_WIDTH-1:0] done_count,
  output logic                   overflow,
  output logic                   order_error
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SLACK);

  grp_state_t             state;
  grp_state_t             state_next;
  logic                   have_row;
  logic                   have_row_next;
  logic                   flush_done;
  logic                   flush_done_next;
  logic                   drain_pending;
  logic [INDEX_WIDTH-1:0] cur_row;
  logic [INDEX_WIDTH-1:0] row_count;

  logic [2*INDEX_WIDTH-1:0] head;
  logic                     fifo_full;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            next_occ;
  logic                     pop;
  logic                     push_acc;
  logic                     new_row;
  logic                     row_change;

  index_fifo #(
    .WIDTH (2 * INDEX_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (index_push),
    .wr_data ({row, col}),
    .rd_en   (out_ready),
    .rd_data (head),
    .valid   (out_valid),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_row  = head[2*INDEX_WIDTH-1:INDEX_WIDTH];
  assign out_col  = head[INDEX_WIDTH-1:0];
  assign pop      = out_valid && out_ready;
  assign push_acc = index_push && (!fifo_full || pop);
  assign next_occ = fifo_count + CW'(push_acc) - CW'(pop);

  assign new_row       = !have_row || (out_row != cur_row);
  assign out_row_start = out_valid && new_row;
  assign row_change    = pop && have_row && (out_row != cur_row);

  // A row closes either on the pop that starts a different row, or one cycle
  // after a flush has drained the FIFO; the two can never coincide because the
  // delayed pulse only fires after have_row has been cleared.
  assign row_done   = row_change || flush_done;
  assign done_row   = row_done ? cur_row   : '0;
  assign done_count = row_done ? row_count : '0;

  always_comb begin
    state_next      = state;
    have_row_next   = have_row;
    flush_done_next = 1'b0;
    drain_pending   = (state == FLUSH_PEND) || flush;
    if (drain_pending && (next_occ == '0)) begin
      flush_done_next = have_row || pop;
      have_row_next   = 1'b0;
      state_next      = IDLE;
    end else begin
      if (pop) have_row_next = 1'b1;
      if (drain_pending)      state_next = FLUSH_PEND;
      else if (have_row_next) state_next = OPEN;
      else                    state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      have_row   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      have_row   <= have_row_next;
      flush_done <= flush_done_next;
    end
  end

  // cur_row and the count survive the return to IDLE so the delayed
  // flush pulse can still report them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_row     <= '0;
      row_count   <= '0;
      stall       <= 1'b0;
      overflow    <= 1'b0;
      order_error <= 1'b0;
    end else begin
      if (pop) begin
        if (new_row) begin
          cur_row   <= out_row;
          row_count <= INDEX_WIDTH'(1);
        end else begin
          row_count <= row_count + 1'b1;
        end
        if (have_row && (out_row < cur_row)) order_error <= 1'b1;
      end
      if (index_push && !push_acc) overflow <= 1'b1;
      stall <= (next_occ >= STALL_AT);
    end
  end

endmodule

// File: tb/tb_index_row_grouper.sv
// Directed bench for index_row_grouper with immediate-assertion checks.
module tb_index_row_grouper;

  logic        rst;
  logic        clk;
  logic        index_push;
  logic [31:0] row;
  logic [31:0] col;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_row;
  logic [31:0] out_col;
  logic        out_row_start;
  logic        row_done;
  logic [31:0] done_row;
  logic [31:0] done_count;
  logic        overflow;
  logic        order_error;

  int test_count;
  int fail_count;

  index_row_grouper #(
    .INDEX_WIDTH (32),
    .DEPTH       (16),
    .SLACK       (4)
  ) dut (
    .rst           (rst),
    .clk           (clk),
    .index_push    (index_push),
    .row           (row),
    .col           (col),
    .flush         (flush),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_row_start (out_row_start),
    .row_done      (row_done),
    .done_row      (done_row),
    .done_count    (done_count),
    .overflow      (overflow),
    .order_error   (order_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic push, input logic [31:0] r, input logic [31:0] c,
                               input logic fl, input logic rdy);
    index_push = push;
    row        = r;
    col        = c;
    flush      = fl;
    out_ready  = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    rst        = 1'b0;
    index_push = 1'b0;
    row        = '0;
    col        = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_row_done", row_done, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_order_error", order_error, 0);
    checkOutput("reset_out_row", out_row, 0);

    // Basic run: (0,1),(0,5),(2,3) then flush on the last pop.
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("basic_empty_valid", out_valid, 0);
    tick();
    applyStimulus(1, 0, 5, 0, 1);
    checkOutput("basic_first_valid", out_valid, 1);
    checkOutput("basic_first_col", out_col, 1);
    checkOutput("basic_first_start", out_row_start, 1);
    checkOutput("basic_first_done", row_done, 0);
    tick();
    applyStimulus(1, 2, 3, 0, 1);
    checkOutput("basic_second_col", out_col, 5);
    checkOutput("basic_second_start", out_row_start, 0);
    checkOutput("basic_second_done", row_done, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("basic_third_row", out_row, 2);
    checkOutput("basic_third_start", out_row_start, 1);
    checkOutput("basic_third_done", row_done, 1);
    checkOutput("basic_third_done_row", done_row, 0);
    checkOutput("basic_third_done_count", done_count, 2);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("basic_final_valid", out_valid, 0);
    checkOutput("basic_final_done", row_done, 1);
    checkOutput("basic_final_done_row", done_row, 2);
    checkOutput("basic_final_done_count", done_count, 1);
    tick();
    checkOutput("basic_after_done", row_done, 0);

    // Backpressure: 12 pushes with out_ready=0 raise stall but not overflow.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 10, i, 0, 0);
      if (i == 11) checkOutput("bp_stall_before", stall, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp_stall_after", stall, 1);
    checkOutput("bp_no_overflow", overflow, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("bp_drained_valid", out_valid, 0);
    checkOutput("bp_drained_stall", stall, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("bp_done", row_done, 1);
    checkOutput("bp_done_row", done_row, 10);
    checkOutput("bp_done_count", done_count, 12);
    tick();

    // Overflow: 17 pushes into 16 entries; the 17th is lost.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 20, 100 + i, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_stall", stall, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("ovf_col_order", out_col, 100 + i);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("ovf_empty_after_16", out_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ovf_done_count", done_count, 16);
    tick();

    // Order check: row 5 then row 3.
    applyStimulus(1, 5, 0, 0, 1);
    tick();
    applyStimulus(1, 3, 0, 0, 1);
    checkOutput("order_no_error_yet", order_error, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("order_start", out_row_start, 1);
    checkOutput("order_done", row_done, 1);
    checkOutput("order_done_row", done_row, 5);
    checkOutput("order_done_count", done_count, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("order_error", order_error, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("order_final_row", done_row, 3);
    tick();

    // Flush while two entries of row 7 are queued and the consumer is stalled.
    applyStimulus(1, 7, 0, 0, 0);
    tick();
    applyStimulus(1, 7, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("fp_hold_done0", row_done, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fp_hold_done1", row_done, 0);
    checkOutput("fp_hold_col", out_col, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fp_hold_done2", row_done, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fp_pop0_start", out_row_start, 1);
    checkOutput("fp_pop0_done", row_done, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fp_pop1_col", out_col, 1);
    checkOutput("fp_pop1_done", row_done, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("fp_final_done", row_done, 1);
    checkOutput("fp_final_row", done_row, 7);
    checkOutput("fp_final_count", done_count, 2);
    tick();
    checkOutput("fp_single_done", row_done, 0);

    // Reset mid-row: row 9 open with count 3.
    applyStimulus(1, 9, 0, 0, 1);
    tick();
    applyStimulus(1, 9, 1, 0, 1);
    tick();
    applyStimulus(1, 9, 2, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_mid_last_start", out_row_start, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_no_done", row_done, 0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_done", row_done, 0);
    checkOutput("rst_mid_done_row", done_row, 0);
    checkOutput("rst_mid_done_count", done_count, 0);
    checkOutput("rst_mid_overflow", overflow, 0);
    checkOutput("rst_mid_order_error", order_error, 0);
    checkOutput("rst_mid_stall", stall, 0);
    checkOutput("rst_mid_start", out_row_start, 0);
    applyStimulus(0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_idle_flush_no_done", row_done, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
